// File: rtl/ufx_pkg.sv
// Shared definitions for the UART-side fx bus master: FSM encoding, command bytes, address width.
package ufx_pkg;

    localparam int ADDR_W = 22;

    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;
    localparam logic [7:0] ACK_WR = 8'h4B;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_AD2,
        ST_AD1,
        ST_AD0,
        ST_DAT,
        ST_WR,
        ST_RD,
        ST_RWAIT,
        ST_TX
    } state_t;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_WR) || (b == CMD_RD);
    endfunction

endpackage

// File: rtl/ufx_if.sv
// UART byte stream, response handshake and fx master bus of ufx_master.
// master = the ufx_master side; slave = UART receiver/transmitter plus interconnect.
interface ufx_if;
    import ufx_pkg::*;

    logic [7:0] rx_data;
    logic       rx_vld;
    logic [7:0] tx_data;
    logic       tx_vld;
    logic       tx_rdy;
    addr_t      ufx_waddr;
    logic       ufx_wr;
    logic [7:0] ufx_data;
    addr_t      ufx_raddr;
    logic       ufx_rd;
    logic [7:0] ufx_q;
    logic [7:0] err_cnt;

    modport master (
        input  rx_data, rx_vld, tx_rdy, ufx_q,
        output tx_data, tx_vld, ufx_waddr, ufx_wr, ufx_data,
               ufx_raddr, ufx_rd, err_cnt
    );

    modport slave (
        output rx_data, rx_vld, tx_rdy, ufx_q,
        input  tx_data, tx_vld, ufx_waddr, ufx_wr, ufx_data,
               ufx_raddr, ufx_rd, err_cnt
    );

endinterface

// File: rtl/ufx_tout.sv
// Inter-byte timeout counter: cleared by i_clr, counts while i_en, saturates at TOUT_CYC-1.
// o_exp is combinational: high while enabled and the count sits at the limit.
module ufx_tout #(
    parameter int TOUT_CYC = 1000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_exp
);

    localparam int CNT_W = (TOUT_CYC > 2) ? $clog2(TOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_exp = i_en && (r_cnt == LIMIT);

endmodule

// File: rtl/ufx_master.sv
// Frames UART bytes into single fx writes/reads; ack 2 cycles after last byte (read: RD_LAT+2).
// One transaction in flight; tx byte held until tx_rdy, bytes arriving meanwhile are counted as overrun.
module ufx_master
    import ufx_pkg::*;
#(
    parameter int         RD_LAT   = 2,
    parameter int         TOUT_CYC = 1000000,
    parameter logic [7:0] HDR      = 8'hA5
) (
    input  logic  clk_sys,
    input  logic  rst_sys,
    ufx_if.master bus
);

    localparam logic [3:0] LAT_LD = 4'(RD_LAT - 1);

    state_t     r_state;
    state_t     w_nxt;
    addr_t      r_addr;
    logic       r_op_wr;
    logic [3:0] r_lat;
    addr_t      r_waddr;
    addr_t      r_raddr;
    logic [7:0] r_data;
    logic [7:0] r_tx_data;
    logic [7:0] r_err;
    logic       r_wr;
    logic       r_rd;
    logic       r_tx_vld;

    logic w_in_frame;
    logic w_tout_exp;
    logic w_err;
    logic w_shift;
    logic w_ld_op;
    logic w_ld_wr;
    logic w_ld_rd;
    logic w_sample;

    assign w_in_frame = (r_state == ST_CMD) || (r_state == ST_AD2) ||
                        (r_state == ST_AD1) || (r_state == ST_AD0) ||
                        (r_state == ST_DAT);

    ufx_tout #(
        .TOUT_CYC (TOUT_CYC)
    ) u_tout (
        .i_clk (clk_sys),
        .i_rst (rst_sys),
        .i_clr (bus.rx_vld),
        .i_en  (w_in_frame),
        .o_exp (w_tout_exp)
    );

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_comb begin
        w_nxt    = r_state;
        w_err    = 1'b0;
        w_shift  = 1'b0;
        w_ld_op  = 1'b0;
        w_ld_wr  = 1'b0;
        w_ld_rd  = 1'b0;
        w_sample = 1'b0;
        // A timeout beats a byte arriving in the same cycle; that byte is lost.
        if (w_tout_exp) begin
            w_nxt = ST_IDLE;
            w_err = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.rx_vld && (bus.rx_data == HDR)) begin
                        w_nxt = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (bus.rx_vld) begin
                        if (is_cmd(bus.rx_data)) begin
                            w_ld_op = 1'b1;
                            w_nxt   = ST_AD2;
                        end else begin
                            w_err = 1'b1;
                            w_nxt = ST_IDLE;
                        end
                    end
                end
                ST_AD2: begin
                    if (bus.rx_vld) begin
                        w_shift = 1'b1;
                        w_nxt   = ST_AD1;
                    end
                end
                ST_AD1: begin
                    if (bus.rx_vld) begin
                        w_shift = 1'b1;
                        w_nxt   = ST_AD0;
                    end
                end
                ST_AD0: begin
                    if (bus.rx_vld) begin
                        w_shift = 1'b1;
                        if (r_op_wr) begin
                            w_nxt = ST_DAT;
                        end else begin
                            w_ld_rd = 1'b1;
                            w_nxt   = ST_RD;
                        end
                    end
                end
                ST_DAT: begin
                    if (bus.rx_vld) begin
                        w_ld_wr = 1'b1;
                        w_nxt   = ST_WR;
                    end
                end
                ST_WR: begin
                    w_err = bus.rx_vld;
                    w_nxt = ST_TX;
                end
                ST_RD: begin
                    w_err = bus.rx_vld;
                    w_nxt = ST_RWAIT;
                end
                ST_RWAIT: begin
                    w_err = bus.rx_vld;
                    if (r_lat == 4'd0) begin
                        w_sample = 1'b1;
                        w_nxt    = ST_TX;
                    end
                end
                ST_TX: begin
                    w_err = bus.rx_vld;
                    if (bus.tx_rdy) begin
                        w_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Strobes and bus fields are registered together so they appear in the same cycle.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            r_addr    <= '0;
            r_op_wr   <= 1'b0;
            r_lat     <= '0;
            r_waddr   <= '0;
            r_raddr   <= '0;
            r_data    <= '0;
            r_tx_data <= '0;
            r_err     <= '0;
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
            r_tx_vld  <= 1'b0;
        end else begin
            r_wr     <= w_ld_wr;
            r_rd     <= w_ld_rd;
            r_tx_vld <= (w_nxt == ST_TX);
            if (w_ld_op) begin
                r_op_wr <= (bus.rx_data == CMD_WR);
            end
            if (w_shift) begin
                r_addr <= {r_addr[ADDR_W-9:0], bus.rx_data};
            end
            if (w_ld_rd) begin
                r_raddr <= {r_addr[ADDR_W-9:0], bus.rx_data};
            end
            if (w_ld_wr) begin
                r_waddr <= r_addr;
                r_data  <= bus.rx_data;
            end
            if (r_state == ST_RD) begin
                r_lat <= LAT_LD;
            end else if (r_state == ST_RWAIT) begin
                r_lat <= r_lat - 4'd1;
            end
            if (r_state == ST_WR) begin
                r_tx_data <= ACK_WR;
            end else if (w_sample) begin
                r_tx_data <= bus.ufx_q;
            end
            if (w_err && (r_err != 8'hFF)) begin
                r_err <= r_err + 8'd1;
            end
        end
    end

    assign bus.tx_data   = r_tx_data;
    assign bus.tx_vld    = r_tx_vld;
    assign bus.ufx_waddr = r_waddr;
    assign bus.ufx_wr    = r_wr;
    assign bus.ufx_data  = r_data;
    assign bus.ufx_raddr = r_raddr;
    assign bus.ufx_rd    = r_rd;
    assign bus.err_cnt   = r_err;

endmodule

// File: tb/tb_ufx_master.sv
// Randomised frame-level bench for ufx_master with a queue scoreboard and an fx slave read-data model.
module tb_ufx_master;
    import ufx_pkg::*;

    localparam int         RD_LAT = 2;
    localparam int         TOUT   = 100;
    localparam logic [7:0] HDR    = 8'hA5;

    typedef struct packed {
        logic [21:0] a;
        logic [7:0]  d;
    } wr_t;

    logic clk_sys = 1'b0;
    logic rst_sys = 1'b1;

    ufx_if bus();

    ufx_master #(
        .RD_LAT   (RD_LAT),
        .TOUT_CYC (TOUT),
        .HDR      (HDR)
    ) dut (
        .clk_sys (clk_sys),
        .rst_sys (rst_sys),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          tx_acc  = 0;
    int          err_exp = 0;
    bit          force_stall = 1'b0;
    wr_t         exp_wr_q[$];
    logic [21:0] exp_rd_q[$];
    logic [7:0]  exp_tx_q[$];
    logic [7:0]  rdata_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_sys);
        bus.rx_data = b;
        bus.rx_vld  = 1'b1;
        @(negedge clk_sys);
        bus.rx_vld  = 1'b0;
    endtask

    task automatic gap(input int g);
        if (g < 0) idle($urandom_range(0, 3));
        else       idle(g);
    endtask

    // Reference model: a complete write frame produces one write and one ack byte.
    task automatic write_frame(input logic [23:0] a, input logic [7:0] d, input int g);
        exp_wr_q.push_back({a[21:0], d});
        exp_tx_q.push_back(ACK_WR);
        gap(g); send_byte(HDR);
        gap(g); send_byte(CMD_WR);
        gap(g); send_byte(a[23:16]);
        gap(g); send_byte(a[15:8]);
        gap(g); send_byte(a[7:0]);
        gap(g); send_byte(d);
    endtask

    // A complete read frame produces one read; the slave's data comes back as the tx byte.
    task automatic read_frame(input logic [23:0] a, input logic [7:0] d, input int g);
        exp_rd_q.push_back(a[21:0]);
        rdata_q.push_back(d);
        exp_tx_q.push_back(d);
        gap(g); send_byte(HDR);
        gap(g); send_byte(CMD_RD);
        gap(g); send_byte(a[23:16]);
        gap(g); send_byte(a[15:8]);
        gap(g); send_byte(a[7:0]);
    endtask

    task automatic wait_tx(input int tgt);
        int n = 0;
        while ((tx_acc < tgt) && (n < 400)) begin
            @(negedge clk_sys);
            n++;
        end
        chk("tx_delivered", tx_acc >= tgt, 1);
    endtask

    task automatic wait_tx_vld();
        int n = 0;
        while (!bus.tx_vld && (n < 50)) begin
            @(negedge clk_sys);
            n++;
        end
        chk("tx_vld_rise", bus.tx_vld, 1);
    endtask

    task automatic check_zero(input string p);
        chk({p, "_tx_vld"},  bus.tx_vld,    0);
        chk({p, "_tx_data"}, bus.tx_data,   0);
        chk({p, "_waddr"},   bus.ufx_waddr, 0);
        chk({p, "_wr"},      bus.ufx_wr,    0);
        chk({p, "_data"},    bus.ufx_data,  0);
        chk({p, "_raddr"},   bus.ufx_raddr, 0);
        chk({p, "_rd"},      bus.ufx_rd,    0);
        chk({p, "_err"},     bus.err_cnt,   0);
    endtask

    initial begin : tx_ready_gen
        bus.tx_rdy = 1'b0;
        forever begin
            @(negedge clk_sys);
            bus.tx_rdy = force_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: looks just after each rising edge, so inputs still show what the edge sampled.
    initial begin : monitor
        logic       pv, pwr, prd;
        logic [7:0] pd, qpend;
        int         qcnt;
        wr_t        e;
        pv = 1'b0; pwr = 1'b0; prd = 1'b0; pd = 8'h00; qpend = 8'h00; qcnt = 0;
        bus.ufx_q = 8'h00;
        forever begin
            @(posedge clk_sys);
            #1;
            if (!rst_sys) begin
                if (pv && bus.tx_rdy) begin
                    tx_acc++;
                    chk("tx_pending", exp_tx_q.size() > 0, 1);
                    if (exp_tx_q.size() > 0) chk("tx_data", pd, exp_tx_q.pop_front());
                end else if (pv) begin
                    chk("tx_hold_vld", bus.tx_vld, 1);
                    chk("tx_hold_data", bus.tx_data, pd);
                end
            end
            if (bus.ufx_wr) begin
                chk("wr_single", pwr, 0);
                chk("wr_rd_excl", bus.ufx_rd, 0);
                chk("wr_pending", exp_wr_q.size() > 0, 1);
                if (exp_wr_q.size() > 0) begin
                    e = exp_wr_q.pop_front();
                    chk("wr_addr", bus.ufx_waddr, e.a);
                    chk("wr_data", bus.ufx_data, e.d);
                end
            end
            bus.ufx_q = 8'h00;
            if (rst_sys) qcnt = 0;
            if (qcnt > 0) begin
                qcnt--;
                if (qcnt == 0) bus.ufx_q = qpend;
            end
            if (bus.ufx_rd) begin
                chk("rd_single", prd, 0);
                chk("rd_pending", exp_rd_q.size() > 0, 1);
                if (exp_rd_q.size() > 0) chk("rd_addr", bus.ufx_raddr, exp_rd_q.pop_front());
                qpend = (rdata_q.size() > 0) ? rdata_q.pop_front() : 8'h00;
                qcnt  = RD_LAT;
            end
            pv  = bus.tx_vld;
            pd  = bus.tx_data;
            pwr = bus.ufx_wr;
            prd = bus.ufx_rd;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d failed so far", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int          tgt;
        int          kind;
        logic [7:0]  b;
        bus.rx_data = 8'h00;
        bus.rx_vld  = 1'b0;
        rst_sys     = 1'b1;
        idle(3);
        check_zero("reset");
        rst_sys = 1'b0;

        // Directed write with latency checks
        tgt = tx_acc + 1;
        write_frame(24'h012345, 8'h9C, 0);
        chk("wr_lat_strobe", bus.ufx_wr, 1);
        chk("wr_lat_early", bus.tx_vld, 0);
        idle(1);
        chk("wr_lat_vld", bus.tx_vld, 1);
        chk("wr_ack", bus.tx_data, ACK_WR);
        wait_tx(tgt);
        chk("wr_err", bus.err_cnt, err_exp);

        // Directed read, data from the slave model exactly RD_LAT cycles after ufx_rd
        tgt = tx_acc + 1;
        read_frame(24'h3FFFFF, 8'hC3, 0);
        chk("rd_lat_strobe", bus.ufx_rd, 1);
        idle(1);
        chk("rd_lat_early1", bus.tx_vld, 0);
        idle(1);
        chk("rd_lat_early2", bus.tx_vld, 0);
        idle(1);
        chk("rd_lat_vld", bus.tx_vld, 1);
        chk("rd_resp", bus.tx_data, 8'hC3);
        wait_tx(tgt);
        tgt = tx_acc + 1;
        read_frame(24'hFFFFFF, 8'h5E, -1);
        wait_tx(tgt);

        // Bad command, then a good write
        send_byte(HDR);
        send_byte(8'h11);
        idle(3);
        err_exp = sat_inc(err_exp);
        chk("badcmd_err", bus.err_cnt, err_exp);
        tgt = tx_acc + 1;
        write_frame(24'hABCDEF, 8'h17, -1);
        wait_tx(tgt);
        chk("badcmd_after_err", bus.err_cnt, err_exp);

        // Longest allowed inter-byte gap keeps the frame alive
        tgt = tx_acc + 1;
        write_frame(24'h00FACE, 8'h42, 97);
        wait_tx(tgt);
        chk("gap_ok_err", bus.err_cnt, err_exp);

        // Timeout, then the frame tail must not produce a write
        send_byte(HDR); send_byte(CMD_WR); send_byte(8'h01);
        idle(100);
        err_exp = sat_inc(err_exp);
        chk("tout_err", bus.err_cnt, err_exp);
        send_byte(8'h23); send_byte(8'h45); send_byte(8'h9C);
        idle(5);

        // Byte landing in the timeout cycle is dropped
        send_byte(HDR); send_byte(CMD_WR); send_byte(8'h01);
        idle(98);
        send_byte(8'h23);
        err_exp = sat_inc(err_exp);
        send_byte(8'h45); send_byte(8'h67); send_byte(8'h9C);
        idle(5);
        chk("tout_edge_err", bus.err_cnt, err_exp);

        // Backpressure with an overrun byte during the ack
        force_stall = 1'b1;
        tgt = tx_acc + 1;
        write_frame(24'h112233, 8'h44, -1);
        wait_tx_vld();
        send_byte(8'h5A);
        err_exp = sat_inc(err_exp);
        idle(50);
        chk("stall_vld", bus.tx_vld, 1);
        chk("stall_data", bus.tx_data, ACK_WR);
        chk("overrun_err", bus.err_cnt, err_exp);
        force_stall = 1'b0;
        wait_tx(tgt);

        // Reset while the ack is stalled drops tx_vld
        force_stall = 1'b1;
        write_frame(24'h0A0B0C, 8'hD0, -1);
        wait_tx_vld();
        rst_sys = 1'b1;
        idle(1);
        check_zero("rst_tx");
        rst_sys = 1'b0;
        exp_tx_q.delete();
        err_exp = 0;
        force_stall = 1'b0;

        // Reset mid-frame, then a full read
        send_byte(HDR); send_byte(CMD_RD); send_byte(8'h01);
        rst_sys = 1'b1;
        idle(1);
        check_zero("rst_frame");
        rst_sys = 1'b0;
        tgt = tx_acc + 1;
        read_frame(24'h012345, 8'h99, -1);
        wait_tx(tgt);

        // Random traffic with idle-state noise
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                b = 8'($urandom);
                if (b == HDR) b = 8'h00;
                send_byte(b);
            end
            kind = $urandom_range(0, 2);
            tgt  = tx_acc + 1;
            if (kind == 0) begin
                write_frame(24'($urandom), 8'($urandom), -1);
                wait_tx(tgt);
            end else if (kind == 1) begin
                read_frame(24'($urandom), 8'($urandom), -1);
                wait_tx(tgt);
            end else begin
                b = 8'($urandom);
                if (is_cmd(b)) b = 8'h00;
                send_byte(HDR);
                send_byte(b);
                idle(2);
                err_exp = sat_inc(err_exp);
            end
            chk("rand_err", bus.err_cnt, err_exp);
        end

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            send_byte(HDR);
            send_byte(8'h00);
            err_exp = sat_inc(err_exp);
        end
        idle(2);
        chk("err_sat", bus.err_cnt, err_exp);
        tgt = tx_acc + 1;
        write_frame(24'h3C3C3C, 8'hE1, -1);
        wait_tx(tgt);
        chk("err_sat_hold", bus.err_cnt, 8'hFF);

        idle(10);
        chk("left_wr", exp_wr_q.size(), 0);
        chk("left_rd", exp_rd_q.size(), 0);
        chk("left_tx", exp_tx_q.size(), 0);
        chk("left_rdata", rdata_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
